// File: rtl/rr_wr_regfile.sv
// rr_wr_regfile
//   Register file with NWP write ports and one registered read port.
//   Contending writers are served one per cycle by a round-robin arbiter.
//
// Ports
//   clk       single clock, rising edge
//   rst       asynchronous active-low reset
//   wr_req    per-port write request (bit i = port i)
//   wr_addr   packed write addresses, port i at [i*AW +: AW]
//   wr_data   packed write data, port i at [i*W +: W]
//   wr_gnt    one-hot (or zero) combinational grant; the granted write commits at this edge
//   rd_en     read request
//   rd_addr   read address
//   rd_data   registered read data
//   rd_valid  one-cycle flag, rd_data holds a fresh result
module rr_wr_regfile #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  parameter  int NWP   = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = $clog2(NWP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWP-1:0]    wr_req,
  input  logic [NWP*AW-1:0] wr_addr,
  input  logic [NWP*W-1:0]  wr_data,
  output logic [NWP-1:0]    wr_gnt,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [W-1:0]      rd_data,
  output logic              rd_valid
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic          gnt_any;
  logic [AW-1:0] gnt_addr;
  logic [W-1:0]  gnt_data;

  function automatic logic [PW-1:0] wrap_idx(input int v);
    return PW'(v % NWP);
  endfunction

  // Search ports starting at ptr, wrapping; first requester wins.
  always_comb begin
    wr_gnt  = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NWP; k++) begin
      if (!gnt_any && wr_req[wrap_idx(int'(ptr) + k)]) begin
        gnt_any = 1'b1;
        gnt_idx = wrap_idx(int'(ptr) + k);
      end
    end
    if (gnt_any) wr_gnt[gnt_idx] = 1'b1;
  end

  assign gnt_addr = wr_addr[int'(gnt_idx)*AW +: AW];
  assign gnt_data = wr_data[int'(gnt_idx)*W +: W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= wrap_idx(int'(gnt_idx) + 1);
    end
  end

  // Out-of-range write addresses still consume the grant but touch nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (gnt_any && (int'(gnt_addr) < DEPTH)) begin
      mem[gnt_addr] <= gnt_data;
    end
  end

  // Reads sample the pre-write contents, so same-edge read/write returns old data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= (int'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;
      end
    end
  end

endmodule

// File: tb/tb_rr_wr_regfile.sv
module tb_rr_wr_regfile;

  logic clk;
  logic rst;

  // a_*: W=8, DEPTH=4, NWP=2
  logic [1:0]  a_req, a_gnt;
  logic [3:0]  a_addr;
  logic [15:0] a_wdata;
  logic        a_rd_en;
  logic [1:0]  a_rd_addr;
  logic [7:0]  a_rd_data;
  logic        a_rd_valid;

  // b_*: W=8, DEPTH=4, NWP=3
  logic [2:0]  b_req, b_gnt;
  logic [5:0]  b_addr;
  logic [23:0] b_wdata;
  logic        b_rd_en;
  logic [1:0]  b_rd_addr;
  logic [7:0]  b_rd_data;
  logic        b_rd_valid;

  // c_*: W=8, DEPTH=3, NWP=2
  logic [1:0]  c_req, c_gnt;
  logic [3:0]  c_addr;
  logic [15:0] c_wdata;
  logic        c_rd_en;
  logic [1:0]  c_rd_addr;
  logic [7:0]  c_rd_data;
  logic        c_rd_valid;

  int checks;
  int failures;

  rr_wr_regfile #(.W(8), .DEPTH(4), .NWP(2)) u_a (
    .clk(clk), .rst(rst), .wr_req(a_req), .wr_addr(a_addr), .wr_data(a_wdata),
    .wr_gnt(a_gnt), .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid)
  );

  rr_wr_regfile #(.W(8), .DEPTH(4), .NWP(3)) u_b (
    .clk(clk), .rst(rst), .wr_req(b_req), .wr_addr(b_addr), .wr_data(b_wdata),
    .wr_gnt(b_gnt), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid)
  );

  rr_wr_regfile #(.W(8), .DEPTH(3), .NWP(2)) u_c (
    .clk(clk), .rst(rst), .wr_req(c_req), .wr_addr(c_addr), .wr_data(c_wdata),
    .wr_gnt(c_gnt), .rd_en(c_rd_en), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
    .rd_valid(c_rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b0;
    a_req = '0; a_addr = '0; a_wdata = '0; a_rd_en = 1'b0; a_rd_addr = '0;
    b_req = '0; b_addr = '0; b_wdata = '0; b_rd_en = 1'b0; b_rd_addr = '0;
    c_req = '0; c_addr = '0; c_wdata = '0; c_rd_en = 1'b0; c_rd_addr = '0;

    #3;
    check("rst_rd_data", a_rd_data, 8'h00);
    check("rst_rd_valid", a_rd_valid, 1'b0);
    check("rst_gnt_idle", a_gnt, 2'b00);
    #9 rst = 1'b1;
    tick();

    // Reads of every entry after reset
    for (int i = 0; i < 4; i++) begin
      a_rd_en = 1'b1; a_rd_addr = 2'(i);
      tick();
      check($sformatf("init_rd%0d_data", i), a_rd_data, 8'h00);
      check($sformatf("init_rd%0d_valid", i), a_rd_valid, 1'b1);
    end
    a_rd_en = 1'b0;

    // Two ports contend for addr 1
    a_req = 2'b11; a_addr = {2'd1, 2'd1}; a_wdata = {8'h55, 8'hAA};
    #1 check("cont_gnt0", a_gnt, 2'b01);
    tick(); check("cont_gnt1", a_gnt, 2'b10);
    tick(); check("cont_gnt2", a_gnt, 2'b01);
    tick(); check("cont_gnt3", a_gnt, 2'b10);
    tick();
    a_req = 2'b00;
    #1 check("cont_idle_gnt", a_gnt, 2'b00);
    a_rd_en = 1'b1; a_rd_addr = 2'd1;
    tick();
    check("cont_rd_data", a_rd_data, 8'h55);
    check("cont_rd_valid", a_rd_valid, 1'b1);
    a_rd_en = 1'b0;
    tick();
    check("hold_rd_data", a_rd_data, 8'h55);
    check("hold_rd_valid", a_rd_valid, 1'b0);

    // Same-edge read/write returns old value
    a_req = 2'b01; a_addr = {2'd0, 2'd2}; a_wdata = {8'h00, 8'h11};
    tick();
    a_wdata = {8'h00, 8'h3C};
    a_rd_en = 1'b1; a_rd_addr = 2'd2;
    #1 check("same_gnt", a_gnt, 2'b01);
    tick();
    a_req = 2'b00;
    check("same_rd_old", a_rd_data, 8'h11);
    tick();
    check("same_rd_new", a_rd_data, 8'h3C);
    check("same_rd_valid", a_rd_valid, 1'b1);

    // Asynchronous reset between edges with ptr=1
    #2 rst = 1'b0;
    #1;
    check("arst_rd_data", a_rd_data, 8'h00);
    check("arst_rd_valid", a_rd_valid, 1'b0);
    a_req = 2'b11;
    #1 check("arst_gnt_ptr0", a_gnt, 2'b01);
    a_req = 2'b00;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_rd_en = 1'b1; a_rd_addr = 2'(i);
      tick();
      check($sformatf("arst_rd%0d", i), a_rd_data, 8'h00);
    end
    a_rd_en = 1'b0;
    a_req = 2'b11; a_addr = {2'd3, 2'd3}; a_wdata = {8'h02, 8'h01};
    #1 check("arst_first_gnt", a_gnt, 2'b01);
    tick();
    a_req = 2'b00;

    // Three ports, port 1 idle
    b_req = 3'b101; b_addr = {2'd3, 2'd0, 2'd0}; b_wdata = {8'h30, 8'h20, 8'h10};
    #1 check("nwp3_gnt0", b_gnt, 3'b001);
    tick(); check("nwp3_gnt1", b_gnt, 3'b100);
    tick(); check("nwp3_gnt2", b_gnt, 3'b001);
    tick(); check("nwp3_gnt3", b_gnt, 3'b100);
    tick();
    b_req = 3'b111; b_addr = {2'd3, 2'd1, 2'd0};
    #1 check("nwp3_all_gnt0", b_gnt, 3'b001);
    tick(); check("nwp3_all_gnt1", b_gnt, 3'b010);
    tick(); check("nwp3_all_gnt2", b_gnt, 3'b100);
    tick();
    b_req = 3'b000;
    b_rd_en = 1'b1; b_rd_addr = 2'd1;
    tick(); check("nwp3_rd1", b_rd_data, 8'h20);
    b_rd_addr = 2'd3;
    tick(); check("nwp3_rd3", b_rd_data, 8'h30);
    b_rd_en = 1'b0;

    // DEPTH=3, out-of-range write
    for (int i = 0; i < 3; i++) begin
      c_req = 2'b01; c_addr = {2'd0, 2'(i)}; c_wdata = {8'h00, 8'hA0 + 8'(i)};
      tick();
    end
    c_req = 2'b10; c_addr = {2'd3, 2'd0}; c_wdata = {8'h7F, 8'h00};
    #1 check("oor_gnt", c_gnt, 2'b10);
    tick();
    c_req = 2'b11; c_addr = {2'd3, 2'd3}; c_wdata = {8'h02, 8'h01};
    #1 check("oor_ptr_adv", c_gnt, 2'b01);
    tick();
    c_req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      c_rd_en = 1'b1; c_rd_addr = 2'(i);
      tick();
      check($sformatf("oor_rd%0d", i), c_rd_data, (i < 3) ? 32'hA0 + 32'(i) : 32'h0);
      check($sformatf("oor_rd%0d_valid", i), c_rd_valid, 1'b1);
    end
    c_rd_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_wr_regfile.md
# rr_wr_regfile

Parametrised register file with `NWP` write ports and one read port. Simultaneous write requests are served one per cycle by a round-robin arbiter, so contending writers alternate fairly. It generalises the single alternating-write register to arbitrary width, depth and write-port count. Reads run concurrently with writes. It sits between several producer blocks and a single consumer that needs shared storage.

## Interface
- `W`, 8, data width in bits (≥1).
- `DEPTH`, 4, number of entries (≥2).
- `NWP`, 2, number of write ports (≥2).
- `AW`, derived `$clog2(DEPTH)`, address width; not overridable.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset. Assertion clears state immediately. Deassertion is synchronised externally.
- `wr_req`  in  NWP  per-port write request; bit i belongs to port i.
- `wr_addr`  in  NWP*AW  packed addresses; port i uses `[i*AW +: AW]`.
- `wr_data`  in  NWP*W  packed data; port i uses `[i*W +: W]`.
- `wr_gnt`  out  NWP  one-hot or zero, combinational. Port i's write commits at this edge.
- `rd_en`  in  1  read request.
- `rd_addr`  in  AW  read address.
- `rd_data`  out  W  registered read data.
- `rd_valid`  out  1  high for one cycle when `rd_data` holds a fresh read result.

## Operation
- Storage: `DEPTH` × `W` registers. All entries are 0 after reset.
- Arbiter state is the priority pointer `ptr` (0..NWP-1). Reset value is 0.
- Grant rule: search ports in order `ptr`, `ptr+1`, … wrapping modulo NWP. The first port with `wr_req` set gets `wr_gnt`. If no request is set, `wr_gnt` = 0.
- On a granted edge for port g:
  - `mem[wr_addr_g]` ← `wr_data_g`.
  - `ptr` ← (g+1) mod NWP.
- With no grant, `ptr` is unchanged.
- Ungranted requesters are not stored. They must hold `wr_req`/`wr_addr`/`wr_data` stable until granted. A requester may drop its request without penalty.
- Out-of-range write address (≥ DEPTH, possible when DEPTH is not a power of 2): the grant is issued and `ptr` advances, but no entry changes.
- Read: with `rd_en`=1 at an edge:
  - `rd_data` ← `mem[rd_addr]` (value before any write at the same edge).
  - `rd_valid` ← 1.
- With `rd_en`=0: `rd_data` holds its value and `rd_valid` ← 0.
- Out-of-range read address returns 0 with `rd_valid`=1.
- Read and write at the same edge to the same address: read returns the old data. The new data is visible to a read issued at the next edge.
- Reset asserted mid-operation:
  - Immediately, all entries and `rd_data` = 0, `rd_valid` = 0, `ptr` = 0.
  - `wr_gnt` then follows the grant rule from `ptr`=0.

## Timing
- Write latency: data is committed at the granted edge and is readable by a read issued at the next edge.
- Read latency: 1 cycle from the `rd_en` edge to `rd_data`/`rd_valid`.
- Sustained throughput: one write and one read per cycle.
- Fairness: a continuously requesting port is granted within NWP cycles.
- Reset values: `rd_data`=0, `rd_valid`=0. `wr_gnt` is combinational from `wr_req` and `ptr`.

## Test plan
- Reset, then `rd_en`=1 on addrs 0..3 at consecutive edges → `rd_data`=0 and `rd_valid`=1 for each, one cycle later.
- NWP=2, both ports request continuously to addr 1 (port0 data 0xAA, port1 data 0x55) for 4 cycles:
  - `wr_gnt` sequence is 01,10,01,10.
  - A read of addr 1 after the final grant → 0x55.
- NWP=3, ports 0 and 2 request, port 1 idle: grants alternate port0, port2, port0; port 1 is never granted.
- Same edge: write 0x3C to addr 2 (old value 0x11) and read addr 2 → `rd_data`=0x11. A read at the next edge → 0x3C.
- Assert `rst` low asynchronously between edges after several writes with `ptr`=1:
  - Immediately `rd_data`=0 and `rd_valid`=0.
  - After release, port0 wins first contention.
  - All entries read back 0.
- DEPTH=3, write 0x7F to addr 3 → grant issued and `ptr` advances. Reads of addrs 0..2 unchanged; a read of addr 3 returns 0.
